// File: rtl/gs_bu_pipe.sv
// Pipelined Gentleman-Sande butterfly for the inverse NTT, modulus Q = 8380417.
//   A = (X + Y) mod Q
//   B = ((X - Y) mod Q) * TF mod Q
// Three register stages share one enable: adv = !out_valid | out_ready.
// Optional feature: define GS_BU_HALVE_EN to multiply both outputs by 2^-1 mod Q
// in the last stage, spreading the n^-1 INTT scaling over the log2(n) layers.
module gs_bu_pipe #(
  parameter int unsigned W = 23,
  parameter int unsigned Q = 8380417
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] TF,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] A,
  output logic [W-1:0] B
);

  localparam logic [W:0]     QW = (W+1)'(Q);
  localparam logic [2*W-1:0] QP = (2*W)'(Q);

  // Shared combinational modular multiplier; operands are canonical, so the
  // remainder always fits in W bits.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % QP);
  endfunction

`ifdef GS_BU_HALVE_EN
  // v * 2^-1 mod Q: an odd v is made even by adding the odd modulus first.
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    logic [W:0] t;
    t = v[0] ? ({1'b0, v} + QW) : {1'b0, v};
    return W'(t >> 1);
  endfunction
`endif

  logic         adv;
  logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [W-1:0] a1_q, a1_d, d1_q, d1_d, tf1_q, tf1_d;
  logic [W-1:0] a2_q, a2_d, p2_q, p2_d;
  logic [W-1:0] a3_q, a3_d, b3_q, b3_d;
  logic [W:0]   sum;
  logic [W:0]   diff;

  // Global pipeline enable; a stalled output freezes every stage.
  always_comb begin
    adv      = !v3_q | out_ready;
    in_ready = adv;
  end

  // Stage 1: modular add and modular subtract.
  always_comb begin
    v1_d  = v1_q;
    a1_d  = a1_q;
    d1_d  = d1_q;
    tf1_d = tf1_q;
    sum   = {1'b0, X} + {1'b0, Y};
    diff  = (X < Y) ? ({1'b0, X} + QW - {1'b0, Y}) : ({1'b0, X} - {1'b0, Y});
    if (adv) begin
      v1_d  = in_valid;
      a1_d  = W'((sum >= QW) ? (sum - QW) : sum);
      d1_d  = W'(diff);
      tf1_d = TF;
    end
  end

  // Stage 2: twiddle multiply of the difference; sum passes through.
  always_comb begin
    v2_d = v2_q;
    a2_d = a2_q;
    p2_d = p2_q;
    if (adv) begin
      v2_d = v1_q;
      a2_d = a1_q;
      p2_d = mul_mod(tf1_q, d1_q);
    end
  end

  // Stage 3: output register, optionally halving both results.
  always_comb begin
    v3_d = v3_q;
    a3_d = a3_q;
    b3_d = b3_q;
    if (adv) begin
      v3_d = v2_q;
`ifdef GS_BU_HALVE_EN
      a3_d = halve(a2_q);
      b3_d = halve(p2_q);
`else
      a3_d = a2_q;
      b3_d = p2_q;
`endif
    end
  end

  // State registers; reset drops every in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      a1_q  <= '0;
      d1_q  <= '0;
      tf1_q <= '0;
      a2_q  <= '0;
      p2_q  <= '0;
      a3_q  <= '0;
      b3_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      a1_q  <= a1_d;
      d1_q  <= d1_d;
      tf1_q <= tf1_d;
      a2_q  <= a2_d;
      p2_q  <= p2_d;
      a3_q  <= a3_d;
      b3_q  <= b3_d;
    end
  end

  // Output drive.
  always_comb begin
    out_valid = v3_q;
    A         = a3_q;
    B         = b3_q;
  end

endmodule

// File: tb/tb_gs_bu_pipe.sv
// Self-checking bench for gs_bu_pipe. Inputs change and outputs are sampled
// on the falling clock edge. Honours GS_BU_HALVE_EN when defined.
module tb_gs_bu_pipe;

  localparam int unsigned W = 23;
  localparam longint      Q = 8380417;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X, Y, TF;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] A, B;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gs_bu_pipe #(.W(W), .Q(int'(Q))) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .TF       (TF),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A        (A),
    .B        (B)
  );

  function automatic longint hv(input longint v);
`ifdef GS_BU_HALVE_EN
    return (v % 2 != 0) ? (v + Q) / 2 : v / 2;
`else
    return v;
`endif
  endfunction

  function automatic longint gold_a(input longint x, input longint y);
    return hv((x + y) % Q);
  endfunction

  function automatic longint gold_b(input longint x, input longint y, input longint tf);
    return hv((((x - y + Q) % Q) * tf) % Q);
  endfunction

  // Sends one vector with out_ready high; returns the result and the number of
  // clock edges from acceptance to out_valid (0 if it never appeared).
  task automatic run_one(input longint x, input longint y, input longint tf,
                         output logic [W-1:0] a, output logic [W-1:0] b, output int lat);
    X = W'(x); Y = W'(y); TF = W'(tf);
    in_valid = 1'b1; out_ready = 1'b1;
    a = '0; b = '0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        a = A; b = B; lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; TF = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (A !== '0) begin errors++; $display("FAIL reset A got %0d want 0", A); end
    checks++; if (B !== '0) begin errors++; $display("FAIL reset B got %0d want 0", B); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic [W-1:0] a, b;
    int lat;
`ifdef GS_BU_HALVE_EN
    longint tx [3] = '{1, 2, 5};
    longint ty [3] = '{2, 2, 3};
    longint tt [3] = '{1, 7, 1};
    longint ea [3] = '{4190210, 2, 4};
    longint eb [3] = '{4190208, 0, 1};
`else
    longint tx [6] = '{5, 3, 8380416, 0, 1234, 8380416};
    longint ty [6] = '{3, 5, 1, 8380416, 1234, 0};
    longint tt [6] = '{1, 1, 2, 5, 999, 8380416};
    longint ea [6] = '{8, 8, 0, 8380416, 2468, 8380416};
    longint eb [6] = '{2, 8380415, 8380413, 5, 0, 1};
`endif
    for (int i = 0; i < $size(tx); i++) begin
      run_one(tx[i], ty[i], tt[i], a, b, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL basic[%0d] latency got %0d want 3", i, lat); end
      checks++; if (a !== W'(ea[i])) begin errors++; $display("FAIL basic[%0d] A got %0d want %0d", i, a, ea[i]); end
      checks++; if (b !== W'(eb[i])) begin errors++; $display("FAIL basic[%0d] B got %0d want %0d", i, b, eb[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    longint vx [5] = '{10, 8380416, 77, 4000000, 0};
    longint vy [5] = '{20, 8380416, 5, 5000000, 1};
    longint vt [5] = '{3, 12345, 8380416, 2, 6000000};
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    logic [W-1:0] pa, pb;
    logic stalled;
    int idx;
    idx = 0; stalled = 1'b0; pa = '0; pb = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 8);
      in_valid  = (idx < 5);
      X  = (idx < 5) ? W'(vx[idx]) : '0;
      Y  = (idx < 5) ? W'(vy[idx]) : '0;
      TF = (idx < 5) ? W'(vt[idx]) : '0;
      #1;
      if (stalled) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold c%0d out_valid got %b want 1", c, out_valid); end
        checks++; if (A !== pa) begin errors++; $display("FAIL stall_hold c%0d A got %0d want %0d", c, A, pa); end
        checks++; if (B !== pb) begin errors++; $display("FAIL stall_hold c%0d B got %0d want %0d", c, B, pb); end
      end
      stalled = out_valid && !out_ready;
      pa = A; pb = B;
      if (stalled) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d got %b want 0", c, in_ready); end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin qa.push_back(A); qb.push_back(B); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (qa.size() != 5) begin errors++; $display("FAIL stall_count got %0d want 5", qa.size()); end
    for (int i = 0; i < 5 && i < qa.size(); i++) begin
      checks++; if (qa[i] !== W'(gold_a(vx[i], vy[i]))) begin errors++; $display("FAIL stall_out[%0d] A got %0d want %0d", i, qa[i], gold_a(vx[i], vy[i])); end
      checks++; if (qb[i] !== W'(gold_b(vx[i], vy[i], vt[i]))) begin errors++; $display("FAIL stall_out[%0d] B got %0d want %0d", i, qb[i], gold_b(vx[i], vy[i], vt[i])); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    X = 5; Y = 3; TF = 1;
    @(negedge clk);
    X = 100; Y = 7; TF = 9;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b want 0", out_valid); end
    checks++; if (A !== '0) begin errors++; $display("FAIL rst_mid A got %0d want 0", A); end
    checks++; if (B !== '0) begin errors++; $display("FAIL rst_mid B got %0d want 0", B); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush cycle %0d out_valid got %b want 0", i, out_valid); end
    end
  endtask

  function automatic longint pick();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 0;
    if (r == 1) return Q - 1;
    if (r == 2) return 1;
    return longint'($urandom_range(0, int'(Q - 1)));
  endfunction

  task automatic test_random();
    localparam int N = 3000;
    longint ea [$];
    longint eb [$];
    longint wa, wb;
    int sent, recv;
    sent = 0; recv = 0;
    for (int c = 0; c < 20000 && recv < N; c++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 9) < 7);
      in_valid  = (sent < N) && ($urandom_range(0, 9) < 7);
      X = W'(pick()); Y = W'(pick()); TF = W'(pick());
      #1;
      if (in_valid && in_ready) begin
        ea.push_back(gold_a(longint'(X), longint'(Y)));
        eb.push_back(gold_b(longint'(X), longint'(Y), longint'(TF)));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (ea.size() == 0) begin
          errors++; $display("FAIL rand_extra output A=%0d B=%0d with no pending input", A, B);
        end else begin
          wa = ea.pop_front(); wb = eb.pop_front();
          if (A !== W'(wa) || B !== W'(wb)) begin
            errors++; $display("FAIL rand[%0d] A/B got %0d/%0d want %0d/%0d", recv, A, B, wa, wb);
          end
        end
        recv++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (recv != N) begin errors++; $display("FAIL rand_count got %0d want %0d", recv, N); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
